jbi_min_wdq_ctl: RTL and testbench



---
 rtl/jbi_min_wdq_ctl_pkg.sv | 20 ++
 rtl/jbi_min_wdq_ctl_eccgen.sv | 29 ++
 rtl/jbi_min_wdq_ctl.sv | 127 ++++++++++++
 tb/tb_jbi_min_wdq_ctl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/jbi_min_wdq_ctl_pkg.sv
// Shared WDQ constants and types: buffer geometry, ECC lane split and pointer width.
package jbi_min_wdq_ctl_pkg;

  localparam int JBI_WDQ_ADDR_WIDTH = 4;
  localparam int JBI_WDQ_WIDTH      = 156;

  localparam int DATA_W = 128;
  localparam int ECC_W  = 7;
  localparam int LANE_W = 32;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int PTR_W  = JBI_WDQ_ADDR_WIDTH + 1;
  localparam int LVL_W  = 5;

  typedef logic [JBI_WDQ_WIDTH-1:0] wdq_entry_t;
  typedef logic [PTR_W-1:0]         wdq_ptr_t;
  typedef logic [LVL_W-1:0]         wdq_lvl_t;

  localparam wdq_ptr_t WDQ_DEPTH = wdq_ptr_t'(1 << JBI_WDQ_ADDR_WIDTH);

endpackage

// File: rtl/jbi_min_wdq_ctl_eccgen.sv
// Combinational SEC-DED check-word generator for one 32-bit data lane.
module jbi_min_wdq_eccgen
  import jbi_min_wdq_ctl_pkg::*;
(
  input  logic [LANE_W-1:0] i_data,
  output logic [ECC_W-1:0]  o_ecc
);

  // Data bits occupy Hamming positions 3..38 skipping powers of two;
  // bit 6 is the overall parity over data and the six check bits.
  function automatic logic [ECC_W-1:0] calc_ecc(input logic [LANE_W-1:0] d);
    logic [5:0] c;
    logic [5:0] idx;
    c   = '0;
    idx = '0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < 6; k++) begin
          if (p[k]) c[k] = c[k] ^ d[idx[4:0]];
        end
        idx = idx + 6'd1;
      end
    end
    return {(^d) ^ (^c), c};
  endfunction

  assign o_ecc = calc_ecc(i_data);

endmodule

// File: rtl/jbi_min_wdq_ctl.sv
// WDQ control: write-side pointer and ECC, read issue into a 2-entry output skid,
// occupancy/status accounting and the head valid/ack handshake.
module jbi_min_wdq_ctl
  import jbi_min_wdq_ctl_pkg::*;
#(
  parameter int AFULL_THRESH = 12
)
(
  input  logic                          clk,
  input  logic                          arst_l,
  input  logic                          wdq_push,
  input  logic [DATA_W-1:0]             wdq_push_data,
  input  logic                          wdq_dout_ack,
  input  logic [JBI_WDQ_WIDTH-1:0]      wdq_rdata,
  output logic                          wdq_wr_en,
  output logic [JBI_WDQ_ADDR_WIDTH-1:0] wdq_waddr,
  output logic [DATA_W-1:0]             wdq_wdata,
  output logic [ECC_W-1:0]              wdq_wdata_ecc0,
  output logic [ECC_W-1:0]              wdq_wdata_ecc1,
  output logic [ECC_W-1:0]              wdq_wdata_ecc2,
  output logic [ECC_W-1:0]              wdq_wdata_ecc3,
  output logic                          wdq_rd_en,
  output logic [JBI_WDQ_ADDR_WIDTH-1:0] wdq_raddr,
  output logic                          wdq_dout_vld,
  output logic [JBI_WDQ_WIDTH-1:0]      wdq_dout,
  output logic [LVL_W-1:0]              wdq_level,
  output logic                          wdq_full,
  output logic                          wdq_afull,
  output logic                          wdq_empty,
  output logic                          wdq_ovf
);

  logic [ECC_W-1:0] w_ecc [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_ecc
    jbi_min_wdq_eccgen u_eccgen (
      .i_data (wdq_push_data[g*LANE_W +: LANE_W]),
      .o_ecc  (w_ecc[g])
    );
  end

  wdq_ptr_t   r_wptr;
  wdq_ptr_t   r_rptr;
  logic       r_inflight;
  logic [1:0] r_skid_cnt;
  logic       r_ovf;
  wdq_entry_t r_head;
  wdq_entry_t r_spare;

  wdq_ptr_t   w_unread;
  logic       w_full;
  logic       w_wr_en;
  logic       w_dout_vld;
  logic       w_ack;
  logic [2:0] w_occ_nxt;
  logic       w_rd_en;
  wdq_lvl_t   w_level;
  wdq_entry_t w_land0;
  wdq_entry_t w_land1;

  // Array side: unread only sees entries written in earlier cycles, so a
  // same-cycle write can never alias the address being read.
  assign w_unread = r_wptr - r_rptr;
  assign w_full   = (w_unread == WDQ_DEPTH);
  assign w_wr_en  = wdq_push & ~w_full;

  // Head is valid from a parked skid entry or directly from read data landing now.
  assign w_dout_vld = (r_skid_cnt != 2'd0) | r_inflight;
  assign w_ack      = wdq_dout_ack & w_dout_vld;

  // Output-stage occupancy after this cycle's landing and ack; a new read may
  // only be issued if its data will have a slot when it lands.
  assign w_occ_nxt = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_ack};
  assign w_rd_en   = (w_unread != '0) && (w_occ_nxt < 3'd2);

  assign w_level = wdq_lvl_t'(w_unread) + wdq_lvl_t'(r_inflight) + wdq_lvl_t'(r_skid_cnt);

  // Ordered view of the output stage: parked entries first, then landing data.
  assign w_land0 = (r_skid_cnt != 2'd0) ? r_head  : wdq_rdata;
  assign w_land1 = (r_skid_cnt == 2'd2) ? r_spare : wdq_rdata;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_skid_cnt <= 2'd0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + wdq_ptr_t'(1);
      if (w_rd_en) r_rptr <= r_rptr + wdq_ptr_t'(1);
      r_inflight <= w_rd_en;
      r_skid_cnt <= w_occ_nxt[1:0];
      if (wdq_push && w_full) r_ovf <= 1'b1;
    end
  end

  // Skid data: validity is carried entirely by r_skid_cnt, so no reset here.
  always_ff @(posedge clk) begin
    r_head  <= w_ack ? w_land1   : w_land0;
    r_spare <= w_ack ? wdq_rdata : w_land1;
  end

  a_ack_needs_vld : assert property (@(posedge clk) disable iff (!arst_l)
                                     wdq_dout_ack |-> w_dout_vld);

  assign wdq_wr_en      = w_wr_en;
  assign wdq_waddr      = r_wptr[JBI_WDQ_ADDR_WIDTH-1:0];
  assign wdq_wdata      = wdq_push_data;
  assign wdq_wdata_ecc0 = w_ecc[0];
  assign wdq_wdata_ecc1 = w_ecc[1];
  assign wdq_wdata_ecc2 = w_ecc[2];
  assign wdq_wdata_ecc3 = w_ecc[3];

  assign wdq_rd_en    = w_rd_en;
  assign wdq_raddr    = r_rptr[JBI_WDQ_ADDR_WIDTH-1:0];
  assign wdq_dout_vld = w_dout_vld;
  assign wdq_dout     = (r_skid_cnt != 2'd0) ? r_head :
                        (r_inflight ? wdq_rdata : '0);

  assign wdq_level = w_level;
  assign wdq_full  = w_full;
  assign wdq_afull = (w_level >= wdq_lvl_t'(AFULL_THRESH));
  assign wdq_empty = (w_level == '0);
  assign wdq_ovf   = r_ovf;

endmodule

// File: tb/tb_jbi_min_wdq_ctl.sv
// Self-checking bench for jbi_min_wdq_ctl: directed steps plus random push/ack
// against a queue-based reference model with a behavioural 16-entry buffer.
module tb_jbi_min_wdq_ctl;

  logic         clk;
  logic         arst_l;
  logic         wdq_push;
  logic [127:0] wdq_push_data;
  logic         wdq_dout_ack;
  logic [155:0] wdq_rdata;
  logic         wdq_wr_en;
  logic [3:0]   wdq_waddr;
  logic [127:0] wdq_wdata;
  logic [6:0]   wdq_wdata_ecc0, wdq_wdata_ecc1, wdq_wdata_ecc2, wdq_wdata_ecc3;
  logic         wdq_rd_en;
  logic [3:0]   wdq_raddr;
  logic         wdq_dout_vld;
  logic [155:0] wdq_dout;
  logic [4:0]   wdq_level;
  logic         wdq_full, wdq_afull, wdq_empty, wdq_ovf;

  jbi_min_wdq_ctl dut (
    .clk            (clk),
    .arst_l         (arst_l),
    .wdq_push       (wdq_push),
    .wdq_push_data  (wdq_push_data),
    .wdq_dout_ack   (wdq_dout_ack),
    .wdq_rdata      (wdq_rdata),
    .wdq_wr_en      (wdq_wr_en),
    .wdq_waddr      (wdq_waddr),
    .wdq_wdata      (wdq_wdata),
    .wdq_wdata_ecc0 (wdq_wdata_ecc0),
    .wdq_wdata_ecc1 (wdq_wdata_ecc1),
    .wdq_wdata_ecc2 (wdq_wdata_ecc2),
    .wdq_wdata_ecc3 (wdq_wdata_ecc3),
    .wdq_rd_en      (wdq_rd_en),
    .wdq_raddr      (wdq_raddr),
    .wdq_dout_vld   (wdq_dout_vld),
    .wdq_dout       (wdq_dout),
    .wdq_level      (wdq_level),
    .wdq_full       (wdq_full),
    .wdq_afull      (wdq_afull),
    .wdq_empty      (wdq_empty),
    .wdq_ovf        (wdq_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x156 buffer with one-cycle read latency
  logic [155:0] mem [16];
  always @(posedge clk) begin
    if (wdq_wr_en) mem[wdq_waddr] <= {wdq_wdata_ecc3, wdq_wdata_ecc2, wdq_wdata_ecc1, wdq_wdata_ecc0, wdq_wdata};
    if (wdq_rd_en) wdq_rdata <= mem[wdq_raddr];
  end

  int           n_pass;
  int           n_chk;
  logic [127:0] q[$];
  bit           m_ovf;
  bit           have_prev;
  logic [3:0]   prev_raddr;
  int           wraps;

  function automatic logic [6:0] ref_ecc32(input logic [31:0] d);
    logic [6:0] e;
    int pos;
    e   = '0;
    pos = 2;
    for (int i = 0; i < 32; i++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[i]) e[5:0] = e[5:0] ^ pos[5:0];
    end
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  function automatic logic [155:0] ref_entry(input logic [127:0] d);
    return {ref_ecc32(d[127:96]), ref_ecc32(d[95:64]), ref_ecc32(d[63:32]), ref_ecc32(d[31:0]), d};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [155:0] obs, input logic [155:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive at negedge, check all model-derived outputs, update model.
  task automatic step(input bit push, input logic [127:0] d, input bit ack_req, input bit exp_acc);
    bit         a;
    logic [3:0] nxt;
    @(negedge clk);
    a = ack_req && wdq_dout_vld;
    wdq_push      = push;
    wdq_push_data = d;
    wdq_dout_ack  = a;
    #1;
    chk("level", wdq_level, q.size());
    chk("empty", wdq_empty, q.size() == 0);
    chk("afull", wdq_afull, q.size() >= 12);
    chk("ovf", wdq_ovf, m_ovf);
    if (q.size() < 16) chk("full_low", wdq_full, 1'b0);
    chk("wr_en", wdq_wr_en, push && exp_acc);
    if (push)
      chk("wr_entry", {wdq_wdata_ecc3, wdq_wdata_ecc2, wdq_wdata_ecc1, wdq_wdata_ecc0, wdq_wdata}, ref_entry(d));
    if (wdq_dout_vld) begin
      if (q.size() == 0) chk("vld_when_empty", wdq_dout_vld, 1'b0);
      else               chk("head", wdq_dout, ref_entry(q[0]));
    end
    if (wdq_rd_en) begin
      if (have_prev) begin
        nxt = prev_raddr + 4'd1;
        chk("raddr_seq", wdq_raddr, nxt);
        if (prev_raddr == 4'd15 && wdq_raddr == 4'd0) wraps++;
      end
      have_prev  = 1'b1;
      prev_raddr = wdq_raddr;
    end
    if (a) void'(q.pop_front());
    if (push && exp_acc)  q.push_back(d);
    if (push && !exp_acc) m_ovf = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld"},   wdq_dout_vld, 1'b0);
    chk({tag, "_rd_en"}, wdq_rd_en, 1'b0);
    chk({tag, "_full"},  wdq_full, 1'b0);
    chk({tag, "_afull"}, wdq_afull, 1'b0);
    chk({tag, "_empty"}, wdq_empty, 1'b1);
    chk({tag, "_dout"},  wdq_dout, 156'h0);
    chk({tag, "_level"}, wdq_level, 5'd0);
    chk({tag, "_ovf"},   wdq_ovf, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_chk = 0; m_ovf = 1'b0; have_prev = 1'b0; prev_raddr = '0; wraps = 0;
    arst_l = 1'b0; wdq_push = 1'b0; wdq_push_data = '0; wdq_dout_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    arst_l = 1'b1;

    // Single beat: ECC of 128'h1, read in N+1, head in N+2
    step(1'b1, 128'h1, 1'b0, 1'b1);
    chk("ecc0_of_1", wdq_wdata_ecc0, 7'h43);
    chk("ecc_hi_of_1", {wdq_wdata_ecc3, wdq_wdata_ecc2, wdq_wdata_ecc1}, 21'h0);
    chk("first_waddr", wdq_waddr, 4'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rd_en_n1", wdq_rd_en, 1'b1);
    chk("raddr_n1", wdq_raddr, 4'd0);
    chk("vld_n1", wdq_dout_vld, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("vld_n2", wdq_dout_vld, 1'b1);
    chk("dout_n2", wdq_dout, {21'h0, 7'h43, 128'h1});
    step(1'b0, '0, 1'b0, 1'b0);
    chk("vld_after_ack", wdq_dout_vld, 1'b0);

    // Fill to 18 without acks, then one overflowing push
    for (int k = 0; k <= 18; k++) begin
      step(1'b1, rnd128(), 1'b0, k < 18);
      chk("full_fill", wdq_full, k == 18);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_set", wdq_ovf, 1'b1);
    chk("full_held", wdq_full, 1'b1);

    // Ack every cycle with pushes every other cycle: head never drops
    for (int i = 0; i < 24; i++) begin
      step(i[0], rnd128(), 1'b1, 1'b1);
      chk("no_bubble", wdq_dout_vld, 1'b1);
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("drained_level", wdq_level, 5'd0);
    chk("raddr_wrapped", wraps != 0, 1'b1);

    // Random push/ack, kept below the array-full point
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(1) == 1) && (q.size() < 14), rnd128(), $urandom_range(1) == 1, 1'b1);
    for (int i = 0; i < 60 && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rand_drained", wdq_empty, 1'b1);

    // Async reset at level 7 with a read in flight
    for (int i = 0; i < 8; i++) step(1'b1, rnd128(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst_rd_en", wdq_rd_en, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_level", wdq_level, 5'd7);
    chk("pre_rst_vld", wdq_dout_vld, 1'b1);
    arst_l = 1'b0;
    #1;
    chk_reset_vals("midrst");
    q.delete();
    m_ovf = 1'b0;
    have_prev = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_l = 1'b1;
    step(1'b1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 1'b0, 1'b1);
    chk("restart_waddr", wdq_waddr, 4'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("restart_raddr", wdq_raddr, 4'd0);
    chk("restart_rd_en", wdq_rd_en, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("restart_vld", wdq_dout_vld, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
